// File: rtl/fsm_pkg.sv
// Shared FSM definitions: state encoding reused by the serialiser, the 101 detector and later FSM blocks.
package fsm_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    GAP   = 2'b10
  } state_t;

  // Minimum number of bits needed to index 'value' distinct items.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned w;
    w = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((32'd1 << i) < value) w = i + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/shift_reg_piso.sv
// Parallel-in serial-out register; the serial bit is itself a flop and reads 0 whenever neither loading nor shifting.
module shift_reg_piso #(
  parameter int WIDTH     = 8,
  parameter int MSB_FIRST = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             shift,
  input  logic [WIDTH-1:0] data,
  output logic             sout
);

  logic [WIDTH-1:0] sr;

  // The first bit leaves directly from data on load, so sr keeps only the remaining bits.
  always_ff @(posedge clk) begin
    if (reset) begin
      sr   <= '0;
      sout <= 1'b0;
    end else if (load) begin
      if (MSB_FIRST != 0) begin
        sout <= data[WIDTH-1];
        sr   <= {data[WIDTH-2:0], 1'b0};
      end else begin
        sout <= data[0];
        sr   <= {1'b0, data[WIDTH-1:1]};
      end
    end else if (shift) begin
      if (MSB_FIRST != 0) begin
        sout <= sr[WIDTH-1];
        sr   <= {sr[WIDTH-2:0], 1'b0};
      end else begin
        sout <= sr[0];
        sr   <= {1'b0, sr[WIDTH-1:1]};
      end
    end else begin
      sout <= 1'b0;
      sr   <= '0;
    end
  end

endmodule

// File: rtl/serial_frame_tx.sv
// Word serialiser feeding the 101 detector: valid/ready word input, one bit per clock out, optional idle gap after each word.
module serial_frame_tx #(
  parameter int WIDTH      = 8,
  parameter int MSB_FIRST  = 1,
  parameter int GAP_CYCLES = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             sout,
  output logic             sout_valid,
  output logic             word_done,
  output logic             busy
);
  import fsm_pkg::*;

  localparam int unsigned     CNT_W    = clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST    = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] PRE_LAST = CNT_W'(WIDTH - 2);
  localparam bit              NO_GAP   = (GAP_CYCLES == 0);
  localparam logic [3:0]      GAP_LAST = NO_GAP ? 4'd0 : 4'(GAP_CYCLES - 1);

  state_t           state;
  logic [CNT_W-1:0] bit_cnt;
  logic [3:0]       gap_cnt;
  logic             last_bit;
  logic             accept;
  logic             shift;

  assign last_bit = (state == SHIFT) && (bit_cnt == LAST);
  assign in_ready = (state == IDLE) || (last_bit && NO_GAP);
  assign accept   = in_valid && in_ready;
  assign shift    = (state == SHIFT) && !last_bit;

  shift_reg_piso #(
    .WIDTH     (WIDTH),
    .MSB_FIRST (MSB_FIRST)
  ) u_piso (
    .clk   (clk),
    .reset (reset),
    .load  (accept),
    .shift (shift),
    .data  (in_data),
    .sout  (sout)
  );

  // bit_cnt indexes the bit currently on sout; word_done is raised one edge early so it lines up with the last bit.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      bit_cnt    <= '0;
      gap_cnt    <= '0;
      sout_valid <= 1'b0;
      word_done  <= 1'b0;
      busy       <= 1'b0;
    end else begin
      word_done <= shift && (bit_cnt == PRE_LAST);
      case (state)
        IDLE: begin
          if (accept) begin
            state      <= SHIFT;
            bit_cnt    <= '0;
            sout_valid <= 1'b1;
            busy       <= 1'b1;
          end
        end
        SHIFT: begin
          if (last_bit) begin
            bit_cnt <= '0;
            if (accept) begin
              sout_valid <= 1'b1;
            end else if (!NO_GAP) begin
              state      <= GAP;
              gap_cnt    <= '0;
              sout_valid <= 1'b0;
            end else begin
              state      <= IDLE;
              sout_valid <= 1'b0;
              busy       <= 1'b0;
            end
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
        GAP: begin
          if (gap_cnt == GAP_LAST) begin
            state   <= IDLE;
            gap_cnt <= '0;
            busy    <= 1'b0;
          end else begin
            gap_cnt <= gap_cnt + 4'd1;
          end
        end
        default: begin
          state      <= IDLE;
          sout_valid <= 1'b0;
          busy       <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/serial_frame_tx.md
Name: serial_frame_tx

Overview:
- Parallel-to-serial stage that sits directly upstream of the 101 sequence detector. Its sout output drives the detector's din.
- Accepts WIDTH-bit words through a valid/ready handshake and shifts them out one bit per clock.
- sout_valid marks live bits. Optional idle gap cycles separate words.
- Gives the detector a controlled, framed bitstream in integration and test.

Parameters:
- WIDTH, 8: bits per word; legal range 2..32.
- MSB_FIRST, 1: 1 = bit WIDTH-1 goes out first; 0 = bit 0 goes out first.
- GAP_CYCLES, 0: idle cycles inserted after each word; legal range 0..15.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- reset  input  1  synchronous, active-high reset.
- in_data  input  WIDTH  word to serialise.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  block can accept a word this cycle.
- sout  output  1  serial bit; connects to the detector's din.
- sout_valid  output  1  sout carries a live data bit.
- word_done  output  1  one-cycle pulse coincident with the last bit of a word.
- busy  output  1  high in SHIFT or GAP.

Behaviour:
- Clocking and reset: one clock (clk); reset is synchronous and active-high. Reset is sampled only at the rising edge of clk.
- Reset values: state=IDLE, sout=0, sout_valid=0, word_done=0, busy=0, shift register=0, bit counter=0, gap counter=0. in_ready is 1 after reset.
- States: IDLE, SHIFT, GAP. Encoding is 2 bits: IDLE=00, SHIFT=01, GAP=10.
- in_ready is combinational: (state==IDLE) OR (state==SHIFT AND last bit AND GAP_CYCLES==0).
- Accept condition: in_valid AND in_ready at a rising edge. At that edge the block captures in_data, clears the bit counter, and enters or stays in SHIFT.
- in_valid while in_ready=0 is ignored. in_data need not stay stable after accept.
- Latency: the first bit appears on sout in the cycle after the accepting edge. sout and sout_valid are registered.
- Each bit is held for exactly one cycle. A word occupies exactly WIDTH consecutive sout_valid=1 cycles.
- word_done=1 in the cycle sout carries the last bit.
- After the last bit:
  - GAP_CYCLES>0: enter GAP for exactly GAP_CYCLES cycles with sout=0 and sout_valid=0, then go to IDLE.
  - GAP_CYCLES==0 with an accept on the last-bit cycle: the next word's first bit follows with no bubble.
  - GAP_CYCLES==0 with no accept: go to IDLE.
- In IDLE and GAP: sout is forced to 0 and sout_valid=0. The detector sees zeros, so a pattern cannot span a gap.
- Bit counter: width is clog2(WIDTH). It wraps to 0 on the last bit and never exceeds WIDTH-1.
- Reset mid-word or mid-gap: the word is dropped. At the next edge all outputs take their reset values, and no word_done pulse is issued for the aborted word.
- reset and in_valid together: reset wins and no word is captured.
- busy = (state != IDLE), registered alongside the state.

Decomposition:
- Shared package (fsm_pkg) holds the state encoding constants IDLE/SHIFT/GAP (2-bit) and a clog2 function. The detector and later FSM blocks reuse them.
- One natural sub-module: shift_reg_piso. It provides parallel load, direction from MSB_FIRST, and a serial output bit. The FSM, counters and handshake stay in serial_frame_tx.

Test Plan:
1. MSB_FIRST=1, GAP=0; reset for 2 cycles, then accept 8'hA5.
   - sout = 1,0,1,0,0,1,0,1 on 8 consecutive cycles starting one cycle after accept.
   - sout_valid high for exactly those 8 cycles; word_done only on the 8th.
2. GAP=0, in_valid held high with 8'hA5 then 8'h5A.
   - 16 contiguous valid bits: 10100101 01011010.
   - in_ready=1 only in IDLE and on the last-bit cycle.
3. GAP_CYCLES=2, two words 8'hFF and 8'hFF.
   - Exactly 2 cycles with sout=0, sout_valid=0 between the words.
   - in_ready=0 during the gap and 1 afterwards.
4. Accept 8'hF0, assert reset on the 4th bit cycle.
   - Next cycle: sout=0, sout_valid=0, busy=0, in_ready=1, no word_done.
   - A following word 8'h81 serialises cleanly as 1,0,0,0,0,0,0,1.
5. MSB_FIRST=0, word 8'h01.
   - First sout bit is 1, followed by seven 0s; word_done on the 8th bit.
6. Integration: sout drives the 101 detector with word 8'b1010_0000, GAP=0.
   - The detector's dout asserts exactly once.
   - With 8'b1001_0000 the detector's dout never asserts.
